inst_mem_dp: RTL and testbench

//  Parametrised dual-port instruction memory; successor to the single-port 20-bit x 32 store.

---
 rtl/inst_mem_pkg.sv | 6 +
 rtl/mem_clear_seq.sv | 35 +++
 rtl/inst_mem_dp.sv | 69 ++++++
 tb/tb_inst_mem_dp.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared state encoding and read-during-write mode constants
package inst_mem_pkg;
  typedef enum logic {CLEAR, READY} state_e;
  localparam bit RDW_OLD = 1'b0;
  localparam bit RDW_NEW = 1'b1;
endpackage

// File: rtl/mem_clear_seq.sv
// mem_clear_seq: post-reset sweep that writes zero to every word, then releases the memory
module mem_clear_seq
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  // compare against the last address so the pointer never needs an extra bit to overflow
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_e            state;
  logic [ADDR_W-1:0] clr_ptr;
  assign clr_we   = (state == CLEAR);
  assign clr_addr = clr_ptr;
  // sweep one word per cycle; busy drops on the same edge that enters READY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      busy    <= 1'b1;
    end else if (state == CLEAR) begin
      if (clr_ptr == LAST) begin
        state <= READY;
        busy  <= 1'b0;
      end else begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/inst_mem_dp.sv
// inst_mem_dp: dual-port instruction memory with self-clearing sweep and access error flag
module inst_mem_dp #(
  parameter int DATA_W  = 20,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter bit RDW_NEW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              acc_err
);
  // one extra bit so DEPTH == 2**ADDR_W is representable in the range check
  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W + 1)'(DEPTH);
  localparam bit              BYPASS = (RDW_NEW != inst_mem_pkg::RDW_OLD);
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              rd_in, wr_in, rd_ok, wr_ok, same, we, err_nx;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  mem_clear_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_clr (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // qualify requests and steer the single write port between sweep and user
  always_comb begin
    rd_in  = {1'b0, rd_addr} < LIMIT;
    wr_in  = {1'b0, wr_addr} < LIMIT;
    rd_ok  = en & rd_req & ~busy & rd_in;
    wr_ok  = en & wr_req & ~busy & wr_in;
    same   = wr_ok & (wr_addr == rd_addr);
    err_nx = en & ((rd_req & (busy | ~rd_in)) | (wr_req & (busy | ~wr_in)));
    we     = clr_we | wr_ok;
    waddr  = clr_we ? clr_addr : wr_addr;
    wdata  = clr_we ? '0 : wr_data;
  end

  // storage write port, no reset so it maps onto a simple dual-port RAM
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port and error pulse; reset drops any in-flight read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      acc_err  <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      acc_err  <= err_nx;
      if (rd_ok) rd_data <= (BYPASS && same) ? wr_data : mem[rd_addr];
    end
  end
endmodule

// File: tb/tb_inst_mem_dp.sv
// tb_inst_mem_dp: directed checks of sweep, read/write, read-during-write modes and error flag
module tb_inst_mem_dp;
  logic        clk = 1'b0;
  logic        rst, en, rd_req, wr_req;
  logic [4:0]  rd_addr, wr_addr;
  logic [19:0] wr_data;
  logic [19:0] rd_data0, rd_data1, rd_data2;
  logic        rd_valid0, rd_valid1, rd_valid2;
  logic        busy0, busy1, busy2;
  logic        acc_err0, acc_err1, acc_err2;
  int          n_chk = 0;
  int          n_err = 0;
  int          c0, c2;
  logic [19:0] exp_w;

  always #5 clk = ~clk;

  inst_mem_dp #(.DATA_W(20), .ADDR_W(5), .DEPTH(32), .RDW_NEW(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy0), .acc_err(acc_err0));
  inst_mem_dp #(.DATA_W(20), .ADDR_W(5), .DEPTH(32), .RDW_NEW(1'b1)) u1 (
    .clk(clk), .rst(rst), .en(en), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy1), .acc_err(acc_err1));
  inst_mem_dp #(.DATA_W(20), .ADDR_W(5), .DEPTH(24), .RDW_NEW(1'b0)) u2 (
    .clk(clk), .rst(rst), .en(en), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data2),
    .rd_valid(rd_valid2), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy2), .acc_err(acc_err2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic r, input logic [4:0] ra, input logic w, input logic [4:0] wa,
                     input logic [19:0] wd);
    rd_req = r; rd_addr = ra; wr_req = w; wr_addr = wa; wr_data = wd;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1;
    req(0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_busy", busy0, 1);
    chk("rst_valid", rd_valid0, 0);
    chk("rst_err", acc_err0, 0);
    chk("rst_data", rd_data0, 0);
    rst = 1'b1;
    c0 = 0; c2 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) c0++;
      if (busy2) c2++;
      tick();
    end
    chk("sweep_len32", c0, 32);
    chk("sweep_len24", c2, 24);
    chk("ready_busy1", busy1, 0);
    for (int a = 0; a < 32; a++) begin
      req(1, 5'(a), 0, 0, 0);
      tick();
      chk($sformatf("clr_valid@%0d", a), rd_valid0, 1);
      chk($sformatf("clr_data@%0d", a), rd_data0, 0);
    end
    req(0, 0, 1, 7, 20'hABCDE);
    tick();
    chk("wr_no_resp", rd_valid0, 0);
    chk("wr_no_err", acc_err0, 0);
    req(1, 7, 0, 0, 0);
    tick();
    chk("rd7_valid", rd_valid0, 1);
    chk("rd7_data", rd_data0, 20'hABCDE);
    req(0, 0, 1, 3, 20'h00001);
    tick();
    req(1, 3, 1, 3, 20'h12345);
    tick();
    chk("rdw_old", rd_data0, 20'h00001);
    chk("rdw_new", rd_data1, 20'h12345);
    chk("rdw_old24", rd_data2, 20'h00001);
    chk("rdw_valid", rd_valid1, 1);
    req(1, 3, 0, 0, 0);
    tick();
    chk("rd3_after0", rd_data0, 20'h12345);
    chk("rd3_after1", rd_data1, 20'h12345);
    req(1, 7, 1, 9, 20'h55555);
    tick();
    chk("diff_rd7", rd_data0, 20'hABCDE);
    chk("diff_rd7_new", rd_data1, 20'hABCDE);
    req(1, 9, 0, 0, 0);
    tick();
    chk("diff_rd9", rd_data0, 20'h55555);
    req(1, 25, 1, 30, 20'h77777);
    tick();
    chk("oor_err", acc_err2, 1);
    chk("oor_valid", rd_valid2, 0);
    chk("inr_err32", acc_err0, 0);
    chk("inr_valid32", rd_valid0, 1);
    req(0, 0, 0, 0, 0);
    tick();
    chk("oor_pulse1", acc_err2, 0);
    for (int a = 0; a < 24; a++) begin
      exp_w = (a == 3) ? 20'h12345 : (a == 7) ? 20'hABCDE : (a == 9) ? 20'h55555 : 20'h0;
      req(1, 5'(a), 0, 0, 0);
      tick();
      chk($sformatf("d24@%0d", a), rd_data2, exp_w);
    end
    req(1, 24, 0, 0, 0);
    tick();
    chk("rd24_err", acc_err2, 1);
    chk("rd24_valid", rd_valid2, 0);
    req(1, 31, 0, 0, 0);
    tick();
    chk("rd31_valid", rd_valid0, 1);
    chk("rd31_err", acc_err0, 0);
    req(1, 30, 0, 0, 0);
    tick();
    chk("rd30_data", rd_data0, 20'h77777);
    en = 1'b0;
    req(1, 4, 1, 4, 20'hFFFFF);
    tick();
    chk("en0_err", acc_err0, 0);
    chk("en0_valid", rd_valid0, 0);
    en = 1'b1;
    req(1, 4, 0, 0, 0);
    tick();
    chk("en0_rd4", rd_data0, 0);
    chk("en0_rd4_valid", rd_valid0, 1);
    rst = 1'b0;
    #1;
    chk("async_valid", rd_valid0, 0);
    chk("async_busy", busy0, 1);
    req(0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    req(1, 0, 0, 0, 0);
    tick();
    chk("busy_rd_err", acc_err0, 1);
    chk("busy_rd_valid", rd_valid0, 0);
    req(1, 0, 1, 1, 20'h11111);
    tick();
    chk("busy_rw_err", acc_err0, 1);
    req(0, 0, 0, 0, 0);
    tick();
    chk("busy_err_end", acc_err0, 0);
    for (int i = 0; i < 2; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    c0 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) c0++;
      tick();
    end
    chk("resweep_len", c0, 32);
    req(1, 7, 0, 0, 0);
    tick();
    chk("resweep_rd7", rd_data0, 0);
    req(1, 1, 0, 0, 0);
    tick();
    chk("busy_wr_dropped", rd_data0, 0);
    req(0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
